// File: rtl/game_pkg.sv
// Shared encodings and constants for the light-pattern game round controller.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StSettle = 3'd2,
    StEval   = 3'd3,
    StPlay   = 3'd4,
    StWin    = 3'd5
  } state_e;

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  localparam int unsigned       ScoreW   = 8;
  localparam logic [ScoreW-1:0] ScoreMax = '1;

  // Right-shifting Galois step: the bit shifted out folds back through the taps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ LfsrTaps) : (q >> 1);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// Free-running 32-bit Galois LFSR; advances every clock after reset.
module lfsr32
  import game_pkg::*;
#(
  parameter logic [31:0] Seed = 32'hA5C3_0F1E
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] q
);

  logic [31:0] q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= Seed;
    end else begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer: loads a pseudo-random screen, applies moves, and waits out the
// checker's one-cycle latency before judging each result.
module game_round_controller
  import game_pkg::*;
#(
  parameter int unsigned NumberOfBits = 31,
  parameter int unsigned ROUND_CYCLES = 1000,
  parameter int unsigned BUZZ_CYCLES  = 50,
  parameter logic [31:0] SEED         = 32'hA5C3_0F1E,
  localparam int unsigned W    = NumberOfBits + 1,
  localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              move_valid,
  input  logic [IdxW-1:0]   move_idx,
  input  logic              win,
  output logic [W-1:0]      screen_values,
  output logic              move_ready,
  output logic              round_active,
  output logic              buzz,
  output logic              timeout,
  output logic [ScoreW-1:0] score
);

  localparam int unsigned TimerW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam int unsigned BuzzW  = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
  localparam int unsigned ExtW   = IdxW + 1;

  localparam logic [TimerW-1:0] TimerLoad = TimerW'(ROUND_CYCLES - 1);
  localparam logic [BuzzW-1:0]  BuzzLoad  = BuzzW'(BUZZ_CYCLES - 1);
  localparam logic [ExtW-1:0]   WExt      = ExtW'(W);
  localparam logic [ExtW-1:0]   WLast     = ExtW'(W - 1);

  state_e              state_q, state_d;
  logic [W-1:0]        screen_q, screen_d;
  logic [ScoreW-1:0]   score_q, score_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [BuzzW-1:0]    buzz_cnt_q, buzz_cnt_d;
  logic                from_load_q, from_load_d;
  logic                timeout_q, timeout_d;
  logic                move_ready_q, round_active_q, buzz_q;

  logic [31:0]         lfsr_val;
  logic [ExtW-1:0]     idx_ext, idx_nxt;
  logic                idx_ok;
  logic [W-1:0]        move_mask;
  logic                counting, expired;

  lfsr32 #(
    .Seed(SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr_val)
  );

  // Pair toggle of move_idx and its right neighbour, wrapping at the top bit.
  always_comb begin
    idx_ext   = {1'b0, move_idx};
    idx_ok    = idx_ext < WExt;
    idx_nxt   = (idx_ext == WLast) ? '0 : idx_ext + ExtW'(1);
    move_mask = '0;
    for (int unsigned i = 0; i < W; i++) begin
      move_mask[i] = idx_ok && ((ExtW'(i) == idx_ext) || (ExtW'(i) == idx_nxt));
    end
  end

  assign counting = (state_q == StSettle) || (state_q == StEval) || (state_q == StPlay);
  assign expired  = counting && (timer_q == '0);

  always_comb begin
    state_d     = state_q;
    screen_d    = screen_q;
    score_d     = score_q;
    timer_d     = timer_q;
    buzz_cnt_d  = buzz_cnt_q;
    from_load_d = from_load_q;
    timeout_d   = 1'b0;

    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
    end else if (expired) begin
      state_d   = StIdle;
      timeout_d = 1'b1;
    end else begin
      if (counting) begin
        timer_d = timer_q - 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          // Timer is armed here so that a reload pass through LOAD leaves it running.
          if (start) begin
            state_d = StLoad;
            timer_d = TimerLoad;
          end
        end
        StLoad: begin
          screen_d    = lfsr_val[W-1:0];
          from_load_d = 1'b1;
          state_d     = StSettle;
        end
        StSettle: state_d = StEval;
        StEval: begin
          if (win && from_load_q) begin
            state_d = StLoad;
          end else if (win) begin
            score_d    = (score_q == ScoreMax) ? score_q : score_q + 1'b1;
            buzz_cnt_d = BuzzLoad;
            state_d    = StWin;
          end else begin
            state_d = StPlay;
          end
        end
        StPlay: begin
          if (move_valid) begin
            screen_d    = screen_q ^ move_mask;
            from_load_d = 1'b0;
            state_d     = StSettle;
          end
        end
        StWin: begin
          if (buzz_cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            buzz_cnt_d = buzz_cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      screen_q       <= '0;
      score_q        <= '0;
      timer_q        <= '0;
      buzz_cnt_q     <= '0;
      from_load_q    <= 1'b0;
      timeout_q      <= 1'b0;
      move_ready_q   <= 1'b0;
      round_active_q <= 1'b0;
      buzz_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      screen_q       <= screen_d;
      score_q        <= score_d;
      timer_q        <= timer_d;
      buzz_cnt_q     <= buzz_cnt_d;
      from_load_q    <= from_load_d;
      timeout_q      <= timeout_d;
      move_ready_q   <= (state_d == StPlay);
      round_active_q <= (state_d == StLoad) || (state_d == StSettle) ||
                        (state_d == StEval) || (state_d == StPlay);
      buzz_q         <= (state_d == StWin);
    end
  end

  assign screen_values = screen_q;
  assign score         = score_q;
  assign timeout       = timeout_q;
  assign move_ready    = move_ready_q;
  assign round_active  = round_active_q;
  assign buzz          = buzz_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Self-checking bench: table-driven round script, directed corners, and random
// stimulus compared every cycle against a deadline-based reference model.
module tb_game_round_controller;

  localparam int unsigned W    = 32;
  localparam int unsigned RC   = 8;
  localparam int unsigned BC   = 50;
  localparam logic [31:0] Seed = 32'hA5C3_0F1E;
  localparam logic [31:0] Taps = 32'h8020_0003;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        start      = 1'b0;
  logic        stop       = 1'b0;
  logic        move_valid = 1'b0;
  logic [4:0]  move_idx   = '0;
  logic        win        = 1'b0;
  logic [31:0] screen_values;
  logic        move_ready, round_active, buzz, timeout;
  logic [7:0]  score;

  game_round_controller #(
    .NumberOfBits(W - 1),
    .ROUND_CYCLES(RC),
    .BUZZ_CYCLES (BC),
    .SEED        (Seed)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .move_valid   (move_valid),
    .move_idx     (move_idx),
    .win          (win),
    .screen_values(screen_values),
    .move_ready   (move_ready),
    .round_active (round_active),
    .buzz         (buzz),
    .timeout      (timeout),
    .score        (score)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: round expiry and buzz end are absolute cycle numbers.
  typedef enum int {MIdle, MLoad, MSettle, MEval, MPlay, MWin} phase_e;
  phase_e      m_ph;
  logic [31:0] m_screen, m_lfsr;
  int          m_score, now, m_deadline, m_buzz_end;
  bit          m_fresh, m_reload, m_timeout;

  function automatic logic [31:0] galois(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ Taps) : (q >> 1);
  endfunction

  task automatic model_reset();
    m_ph = MIdle; m_screen = '0; m_lfsr = Seed; m_score = 0; now = 0;
    m_deadline = 0; m_buzz_end = 0; m_fresh = 0; m_reload = 0; m_timeout = 0;
  endtask

  task automatic model_step();
    m_timeout = 0;
    now++;
    case (m_ph)
      MIdle: if (start) begin m_ph = MLoad; m_deadline = now + 1 + RC; m_reload = 0; end
      MLoad: begin
        if (stop) m_ph = MIdle;
        else begin
          if (m_reload) m_deadline++;
          m_reload = 0; m_screen = m_lfsr; m_fresh = 1; m_ph = MSettle;
        end
      end
      MSettle, MEval, MPlay: begin
        if (stop) m_ph = MIdle;
        else if (now == m_deadline) begin m_ph = MIdle; m_timeout = 1; end
        else if (m_ph == MSettle) m_ph = MEval;
        else if (m_ph == MEval) begin
          if (win && m_fresh) begin m_ph = MLoad; m_reload = 1; end
          else if (win) begin
            m_score = (m_score >= 255) ? 255 : m_score + 1;
            m_buzz_end = now + BC; m_ph = MWin;
          end else m_ph = MPlay;
        end else if (move_valid) begin
          if (int'(move_idx) < W)
            m_screen = m_screen ^ (32'd1 << move_idx) ^ (32'd1 << ((int'(move_idx) + 1) % W));
          m_fresh = 0; m_ph = MSettle;
        end
      end
      MWin: if (stop || now == m_buzz_end) m_ph = MIdle;
      default: m_ph = MIdle;
    endcase
    m_lfsr = galois(m_lfsr);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("screen", screen_values, m_screen);
    check("move_ready", move_ready, m_ph == MPlay);
    check("round_active", round_active, m_ph inside {MLoad, MSettle, MEval, MPlay});
    check("buzz", buzz, m_ph == MWin);
    check("timeout", timeout, m_timeout);
    check("score", score, 32'(m_score));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic to_play();
    start = 1; cycle(); start = 0; cycle(); cycle(); win = 0; cycle();
  endtask

  task automatic win_round(input int idx);
    to_play();
    move_valid = 1; move_idx = 5'(idx); cycle(); move_valid = 0;
    cycle(); win = 1; cycle(); win = 0;
  endtask

  typedef struct {
    logic st, sp, mv; logic [4:0] idx; logic w;
    logic mr, ra, bz, to; logic [7:0] sc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic st, sp, mv, input logic [4:0] idx, input logic w,
                     input logic mr, ra, bz, to, input logic [7:0] sc);
    vec_t v;
    v.st = st; v.sp = sp; v.mv = mv; v.idx = idx; v.w = w;
    v.mr = mr; v.ra = ra; v.bz = bz; v.to = to; v.sc = sc;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    int n;
    model_reset();
    #1 reset = 0;
    repeat (3) cycle();
    check("rst_screen", screen_values, 32'h0);
    check("rst_score", score, 32'h0);
    check("rst_flags", {move_ready, round_active, buzz, timeout}, 32'h0);
    reset = 1;
    cycle(); cycle();

    //  st sp mv idx w   mr ra bz to sc
    add(1, 0, 0, 0,  0,  0, 1, 0, 0, 0);  // LOAD
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 0);  // SETTLE
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 0);  // EVAL
    add(0, 0, 0, 0,  0,  1, 1, 0, 0, 0);  // PLAY
    add(0, 0, 1, 31, 0,  0, 1, 0, 0, 0);  // wrap-around move
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 0);  // EVAL
    add(0, 0, 0, 0,  1,  0, 0, 1, 0, 1);  // win -> WIN
    add(0, 1, 0, 0,  0,  0, 0, 0, 0, 1);  // stop ends buzz
    add(1, 1, 0, 0,  0,  0, 1, 0, 0, 1);  // start beats stop in IDLE
    add(0, 0, 1, 3,  0,  0, 1, 0, 0, 1);  // move outside PLAY dropped
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 1);  // EVAL
    add(0, 0, 0, 0,  1,  0, 1, 0, 0, 1);  // winning start pattern -> reload
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);  // PLAY
    add(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  0, 0, 0, 1, 1);  // timeout pulse
    add(0, 0, 0, 0,  0,  0, 0, 0, 0, 1);
    add(0, 0, 1, 7,  0,  0, 0, 0, 0, 1);  // move ignored in IDLE
    add(1, 0, 0, 0,  0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 0,  1,  0, 1, 0, 0, 1);  // reload
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);
    add(0, 0, 1, 5,  0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
    add(0, 1, 0, 0,  1,  0, 0, 0, 0, 1);  // stop beats win in EVAL
    add(1, 0, 0, 0,  1,  0, 1, 0, 0, 1);  // win ignored in IDLE
    add(0, 1, 0, 0,  0,  0, 0, 0, 0, 1);  // stop in LOAD

    foreach (tbl[i]) begin
      start = tbl[i].st; stop = tbl[i].sp; move_valid = tbl[i].mv;
      move_idx = tbl[i].idx; win = tbl[i].w;
      prev = m_screen;
      cycle();
      check($sformatf("tbl%0d.move_ready", i), move_ready, tbl[i].mr);
      check($sformatf("tbl%0d.round_active", i), round_active, tbl[i].ra);
      check($sformatf("tbl%0d.buzz", i), buzz, tbl[i].bz);
      check($sformatf("tbl%0d.timeout", i), timeout, tbl[i].to);
      check($sformatf("tbl%0d.score", i), score, tbl[i].sc);
      if (i == 4) check("wrap_move", screen_values, prev ^ 32'h8000_0001);
    end
    start = 0; stop = 0; move_valid = 0; win = 0;
    cycle();

    // Buzz lasts exactly BC cycles after a real win.
    win_round(0);
    check("win_score", score, 32'd2);
    n = 0;
    while (buzz && n < 200) begin cycle(); n++; end
    check("buzz_len", n, BC);

    // Timeout lands RC cycles after the LOAD edge.
    start = 1; cycle(); start = 0;
    n = 0;
    while (!timeout && n < 50) begin cycle(); n++; end
    check("timeout_at", n, RC + 1);
    cycle();

    // Score saturation.
    for (int r = 0; r < 260; r++) begin
      win_round(r % 32);
      stop = 1; cycle(); stop = 0;
    end
    check("score_sat", score, 32'd255);

    // Asynchronous reset mid-round.
    to_play();
    #2 reset = 0;
    #1;
    check("arst_screen", screen_values, 32'h0);
    check("arst_score", score, 32'h0);
    check("arst_flags", {move_ready, round_active, buzz, timeout}, 32'h0);
    cycle(); cycle();
    reset = 1;

    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(3) == 0);
      stop       = ($urandom_range(31) == 0);
      move_valid = 1'($urandom_range(1));
      move_idx   = 5'($urandom_range(31));
      win        = ($urandom_range(2) == 0);
      cycle();
    end

    start = 0; stop = 0; move_valid = 0; win = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
